// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The master modport is the loader. The slave modport is the environment:
// the byte source together with the instruction memory write port.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 30
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader.
// Consumes a big-endian 32-bit word count followed by that many big-endian
// instructions. Each instruction is written to consecutive word addresses
// starting at BASE_ADDR. The CPU is held for the whole load.
module imem_loader #(
  parameter int unsigned          ADDR_W    = 30,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          MAX_WORDS = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  imem_loader_if.master      bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  byte_cnt;
  logic [31:0] index;
  logic [31:0] count;
  logic [31:0] shift;

  logic        accept;
  logic        last_byte;
  logic [31:0] word_in;
  logic [31:0] index_inc;

  // The header is checked against the full 32 bits, so huge counts are not truncated.
  function automatic logic hdr_too_big(input logic [31:0] hdr);
    return hdr > 32'(MAX_WORDS);
  endfunction

  // A byte moves only when the source offers it and the loader is in a receive state.
  assign accept    = bus.byte_valid && bus.byte_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign word_in   = {shift[23:0], bus.byte_in};
  assign index_inc = index + 32'd1;

  // State register; reset returns to IDLE at once, abandoning any partial word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next     = state;
    bus.byte_ready = 1'b0;
    bus.wr_en      = 1'b0;
    cpu_hold       = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = HDR;
        end
      end
      HDR: begin
        bus.byte_ready = 1'b1;
        cpu_hold       = 1'b1;
        if (last_byte) begin
          if (word_in == 32'd0) begin
            state_next = FIN;
          end else if (hdr_too_big(word_in)) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        bus.byte_ready = 1'b1;
        cpu_hold       = 1'b1;
        if (last_byte) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        // Single write cycle; no byte is taken, so the source simply waits.
        bus.wr_en = 1'b1;
        cpu_hold  = 1'b1;
        if (index_inc == count) begin
          state_next = FIN;
        end else begin
          state_next = DATA;
        end
      end
      FIN: begin
        done = 1'b1;
        if (start) begin
          state_next = HDR;
        end
      end
      ERR: begin
        error = 1'b1;
        if (start) begin
          state_next = HDR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte assembly, word bookkeeping and the registered write address and data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt    <= 2'd0;
      index       <= 32'd0;
      count       <= 32'd0;
      shift       <= 32'd0;
      bus.wr_addr <= '0;
      bus.wr_data <= 32'd0;
    end else begin
      case (state)
        IDLE, FIN, ERR: begin
          if (start) begin
            byte_cnt <= 2'd0;
            index    <= 32'd0;
          end
        end
        HDR: begin
          if (accept) begin
            shift    <= word_in;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              count <= word_in;
            end
          end
        end
        DATA: begin
          if (accept) begin
            shift    <= word_in;
            byte_cnt <= byte_cnt + 2'd1;
            // Address and data are captured one cycle early so they are
            // already stable for the whole wr_en cycle.
            if (byte_cnt == 2'd3) begin
              bus.wr_data <= word_in;
              bus.wr_addr <= BASE_ADDR + ADDR_W'(index);
            end
          end
        end
        WRITE: begin
          index <= index_inc;
        end
        default: begin
          byte_cnt <= byte_cnt;
        end
      endcase
    end
  end

endmodule
